// File: rtl/clock_div_scheduler_if.sv
// Configuration write port for clock_div_scheduler: valid/ready request carrying
// target channel, enable flag and terminal count.
interface clock_div_scheduler_if #(
  parameter int NUM_CH      = 4,
  parameter int COUNT_WIDTH = 24
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CH_W-1:0]        cfg_ch;
  logic                   cfg_en;
  logic [COUNT_WIDTH-1:0] cfg_period;

  modport master (
    output cfg_valid, cfg_ch, cfg_en, cfg_period,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_en, cfg_period,
    output cfg_ready
  );
endinterface

// File: rtl/clock_div_scheduler.sv
// Multi-channel clock divider with a sequenced configuration port.
// Define CLKDIV_SCHED_SYNC_UPDATE_EN to defer re-enables of running channels to their wrap edge.
module clock_div_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                clk,
  input  logic                rst,
  clock_div_scheduler_if.slave cfg,
  output logic [NUM_CH-1:0]   out,
  output logic [NUM_CH-1:0]   tick
);
  localparam int CH_W = $clog2(NUM_CH);

`ifdef CLKDIV_SCHED_SYNC_UPDATE_EN
  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT} state_t;
`else
  typedef enum logic {S_IDLE, S_APPLY} state_t;
`endif

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        pend_ch_q, pend_ch_d;
  logic                   pend_en_q, pend_en_d;
  logic [COUNT_WIDTH-1:0] pend_period_q, pend_period_d;

  logic [NUM_CH-1:0]      en_q, en_d;
  logic [NUM_CH-1:0]      out_q, out_d;
  logic [NUM_CH-1:0]      tick_q, tick_d;
  logic [COUNT_WIDTH-1:0] period_q [NUM_CH];
  logic [COUNT_WIDTH-1:0] period_d [NUM_CH];
  logic [COUNT_WIDTH-1:0] count_q  [NUM_CH];
  logic [COUNT_WIDTH-1:0] count_d  [NUM_CH];

  assign cfg.cfg_ready = (state_q == S_IDLE);
  assign out           = out_q;
  assign tick          = tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pend_ch_q     <= '0;
      pend_en_q     <= 1'b0;
      pend_period_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_ch_q     <= pend_ch_d;
      pend_en_q     <= pend_en_d;
      pend_period_q <= pend_period_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_ch_d     = pend_ch_q;
    pend_en_d     = pend_en_q;
    pend_period_d = pend_period_q;
    case (state_q)
      S_IDLE: begin
        if (cfg.cfg_valid) begin
          pend_ch_d     = cfg.cfg_ch;
          pend_en_d     = cfg.cfg_en;
          pend_period_d = cfg.cfg_period;
`ifdef CLKDIV_SCHED_SYNC_UPDATE_EN
          if (cfg.cfg_en && en_q[cfg.cfg_ch]) state_d = S_WAIT;
          else                                state_d = S_APPLY;
`else
          state_d = S_APPLY;
`endif
        end
      end
      S_APPLY: state_d = S_IDLE;
`ifdef CLKDIV_SCHED_SYNC_UPDATE_EN
      S_WAIT: begin
        if (count_q[pend_ch_q] == period_q[pend_ch_q]) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= '0;
      out_q    <= '0;
      tick_q   <= '0;
      period_q <= '{default: '0};
      count_q  <= '{default: '0};
    end else begin
      en_q     <= en_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      en_d[i]     = en_q[i];
      period_d[i] = period_q[i];
      count_d[i]  = '0;
      out_d[i]    = 1'b0;
      tick_d[i]   = 1'b0;
      if (en_q[i]) begin
        if (count_q[i] == period_q[i]) begin
          out_d[i]  = ~out_q[i];
          tick_d[i] = 1'b1;
        end else begin
          count_d[i] = count_q[i] + 1'b1;
          out_d[i]   = out_q[i];
        end
      end
    end

    // A direct write overrides the free-running update of its target only.
    if (state_q == S_APPLY) begin
      en_d[pend_ch_q]    = pend_en_q;
      count_d[pend_ch_q] = '0;
      tick_d[pend_ch_q]  = 1'b0;
      if (pend_en_q) begin
        period_d[pend_ch_q] = pend_period_q;
        out_d[pend_ch_q]    = out_q[pend_ch_q];
      end else begin
        out_d[pend_ch_q]    = 1'b0;
      end
    end

`ifdef CLKDIV_SCHED_SYNC_UPDATE_EN
    // Deferred write lands on the wrap edge, where count already returns to 0 and out toggles.
    if ((state_q == S_WAIT) && (count_q[pend_ch_q] == period_q[pend_ch_q])) begin
      period_d[pend_ch_q] = pend_period_q;
    end
`endif
  end
endmodule

// File: tb/tb_clock_div_scheduler.sv
// Self-checking bench for clock_div_scheduler: directed vector table, hand sequences
// and randomized requests against a per-channel closed-form timing model.
module tb_clock_div_scheduler;
  localparam int NUM_CH = 4;
  localparam int CW     = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] out;
  logic [NUM_CH-1:0] tick;

  clock_div_scheduler_if #(.NUM_CH(NUM_CH), .COUNT_WIDTH(CW)) cfg_if ();

  clock_div_scheduler #(.NUM_CH(NUM_CH), .COUNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .cfg  (cfg_if),
    .out  (out),
    .tick (tick)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  longint cyc  = 0;

  // Model: each enabled channel is a segment starting at edge m_start with out m_out0.
  bit     m_en    [NUM_CH];
  longint m_start [NUM_CH];
  longint m_per   [NUM_CH];
  bit     m_out0  [NUM_CH];
  bit     m_tick0 [NUM_CH];
  int     m_st;           // 0 idle, 1 apply pending, 2 waiting for wrap
  int     p_ch;
  bit     p_en;
  longint p_per;
  bit     acc;

  typedef struct {
    int     ch;
    bit     en;
    longint per;
  } req_t;
  req_t rq[$];

  typedef struct {
    bit       v;
    int       ch;
    bit       en;
    int       per;
    bit       rdy;
    logic [3:0] o;
    logic [3:0] t;
  } row_t;
  row_t tbl [19];

  function automatic bit f_out(int c, longint t);
    longint d;
    if (!m_en[c]) return 1'b0;
    d = t - m_start[c];
    if (d <= 0) return m_out0[c];
    return m_out0[c] ^ bit'((d / (m_per[c] + 1)) % 2);
  endfunction

  function automatic bit f_tick(int c, longint t);
    longint d;
    if (!m_en[c]) return 1'b0;
    d = t - m_start[c];
    if (d == 0) return m_tick0[c];
    return ((d % (m_per[c] + 1)) == 0);
  endfunction

  function automatic bit f_wrap(int c, longint t);
    return m_en[c] && (t > m_start[c]) && (((t - m_start[c]) % (m_per[c] + 1)) == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int old;
    bit o;
    old = m_st;
    acc = 1'b0;
    if (old == 1) begin
      if (p_en) begin
        o = f_out(p_ch, cyc - 1);
        m_en[p_ch] = 1'b1; m_start[p_ch] = cyc; m_per[p_ch] = p_per;
        m_out0[p_ch] = o;  m_tick0[p_ch] = 1'b0;
      end else begin
        m_en[p_ch] = 1'b0;
      end
      m_st = 0;
    end else if (old == 2) begin
      if (f_wrap(p_ch, cyc)) begin
        o = f_out(p_ch, cyc);
        m_start[p_ch] = cyc; m_per[p_ch] = p_per;
        m_out0[p_ch] = o;    m_tick0[p_ch] = 1'b1;
        m_st = 0;
      end
    end
    if (old == 0 && cfg_if.cfg_valid) begin
      acc   = 1'b1;
      p_ch  = int'(cfg_if.cfg_ch);
      p_en  = cfg_if.cfg_en;
      p_per = longint'(cfg_if.cfg_period);
`ifdef CLKDIV_SCHED_SYNC_UPDATE_EN
      m_st = (p_en && m_en[p_ch]) ? 2 : 1;
`else
      m_st = 1;
`endif
    end
  endtask

  task automatic step();
    logic [3:0] eo, et;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      eo[c] = f_out(c, cyc);
      et[c] = f_tick(c, cyc);
    end
    check("model_out", 32'(out), 32'(eo));
    check("model_tick", 32'(tick), 32'(et));
    check("model_ready", 32'(cfg_if.cfg_ready), 32'(m_st == 0));
  endtask

  task automatic drive_q();
    if (rq.size() > 0) begin
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_ch     = 2'(rq[0].ch);
      cfg_if.cfg_en     = rq[0].en;
      cfg_if.cfg_period = 24'(rq[0].per);
    end else begin
      cfg_if.cfg_valid  = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      drive_q();
      step();
      if (acc) void'(rq.pop_front());
    end
    drive_q();
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while ((rq.size() > 0 || m_st != 0) && b < budget) begin
      run(1);
      b++;
    end
    check("drain_timeout", 32'(rq.size() > 0 || m_st != 0), 32'd0);
  endtask

  task automatic push(input int ch, input bit en, input longint per);
    req_t r;
    r.ch = ch; r.en = en; r.per = per;
    rq.push_back(r);
  endtask

  task automatic disable_all();
    for (int c = 0; c < NUM_CH; c++) push(c, 1'b0, 0);
    drain(100);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    for (int c = 0; c < NUM_CH; c++) m_en[c] = 1'b0;
    m_st = 0;
    rq.delete();
    cfg_if.cfg_valid = 1'b0;
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #3 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t_acc1, t_acc2, lowcnt, exp_low;
    bit   b, tk;
    req_t r;

    tbl[0]  = '{1'b1, 0, 1'b1, 3, 1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0001, 4'b0001};
    tbl[6]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0001, 4'b0000};
    tbl[7]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0001, 4'b0000};
    tbl[8]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0001, 4'b0000};
    tbl[9]  = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0000, 4'b0001};
    tbl[10] = '{1'b1, 1, 1'b1, 0, 1'b0, 4'b0000, 4'b0000};
    tbl[11] = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};
    tbl[12] = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0010, 4'b0010};
    tbl[13] = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0001, 4'b0011};
    tbl[14] = '{1'b1, 1, 1'b0, 0, 1'b0, 4'b0011, 4'b0010};
    tbl[15] = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0001, 4'b0000};
    tbl[16] = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0001, 4'b0000};
    tbl[17] = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0000, 4'b0001};
    tbl[18] = '{1'b0, 0, 1'b0, 0, 1'b1, 4'b0000, 4'b0000};

    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_en     = 1'b0;
    cfg_if.cfg_period = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 1'b0; m_start[c] = 0; m_per[c] = 0; m_out0[c] = 1'b0; m_tick0[c] = 1'b0;
    end
    m_st = 0;

    @(posedge clk); @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors: ch0 period 3, then ch1 period 0 enabled and disabled.
    for (int i = 0; i < 19; i++) begin
      cfg_if.cfg_valid  = tbl[i].v;
      cfg_if.cfg_ch     = 2'(tbl[i].ch);
      cfg_if.cfg_en     = tbl[i].en;
      cfg_if.cfg_period = 24'(tbl[i].per);
      step();
      check($sformatf("tbl%0d_ready", i), 32'(cfg_if.cfg_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].o));
      check($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].t));
    end
    cfg_if.cfg_valid = 1'b0;
    disable_all();

    // Back-to-back requests held on the port: second accepted two edges after the first.
    push(2, 1'b1, 2);
    push(3, 1'b1, 1);
    t_acc1 = -1; t_acc2 = -1;
    for (int k = 0; k < 20 && (rq.size() > 0 || m_st != 0); k++) begin
      run(1);
      if (acc && t_acc1 < 0) t_acc1 = int'(cyc);
      else if (acc && t_acc2 < 0) t_acc2 = int'(cyc);
    end
    check("b2b_gap", 32'(t_acc2 - t_acc1), 32'd2);
    run(12);
    disable_all();

    // Period change on a running channel: period 9, rewrite to 1 at count 2.
    push(0, 1'b1, 9);
    drain(50);
    run(2);
    push(0, 1'b1, 1);
`ifdef CLKDIV_SCHED_SYNC_UPDATE_EN
    exp_low = 7;
`else
    exp_low = 1;
`endif
    lowcnt = 0;
    for (int k = 0; k < 20 && (rq.size() > 0 || !cfg_if.cfg_ready); k++) begin
      run(1);
      if (!cfg_if.cfg_ready) lowcnt++;
    end
    check("sync_ready_low", 32'(lowcnt), 32'(exp_low));
    run(20);
    disable_all();

    // ch0 and ch2 period 4, ch2 started on a ch0 wrap so both stay phase-aligned.
    push(0, 1'b1, 4);
    drain(50);
    run(8);
    push(2, 1'b1, 4);
    run(2);
    for (int k = 11; k <= 30; k++) begin
      run(1);
      b  = bit'((k / 5) % 2);
      tk = ((k % 5) == 0);
      check($sformatf("aligned_k%0d", k), 32'({out[2], out[0], tick[2], tick[0]}),
            32'({b, b, tk, tk}));
    end
    disable_all();

    // All-ones period is accepted and simply never wraps within the window.
    push(3, 1'b1, (64'd1 << CW) - 1);
    drain(50);
    run(30);
    check("max_period_out", 32'(out[3]), 32'd0);
    disable_all();

    // Randomized requests.
    for (int i = 0; i < 60; i++) begin
      r.ch  = $urandom_range(0, NUM_CH - 1);
      r.en  = ($urandom_range(0, 3) != 0);
      r.per = $urandom_range(0, 12);
      rq.push_back(r);
      run($urandom_range(0, 8));
    end
    drain(2000);
    run(20);

    // Reset while a rewrite of a running channel is outstanding.
    disable_all();
    push(0, 1'b1, 9);
    drain(50);
    run(2);
    push(0, 1'b1, 1);
    run(1);
    check("pre_rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    do_reset();
    run(25);
    check("post_rst_out", 32'(out), 32'd0);
    check("post_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
